// File: rtl/array_sort_check_seq.sv
`default_nettype none
// ============================================================================
// Module   : array_sort_check_seq
// Purpose  : Walks an array held in a synchronous-read memory and reports
//            whether it is ordered (ascending/descending, strict or not),
//            plus the index of the first out-of-order element.
//            Optional build macro SORTCHK_COUNT_EN: scan the whole array and
//            also report the number of inversion pairs on inv_count.
// Revision : 1.0 - initial release
// ============================================================================
module array_sort_check_seq #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int SIGNED = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [ADDR_W:0]   length,
   input  logic              descending,
   input  logic              strict,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              sorted,
   output logic [ADDR_W-1:0] inv_index
`ifdef SORTCHK_COUNT_EN
   ,
   output logic [ADDR_W:0]   inv_count
`endif
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_SCAN = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam logic [ADDR_W:0] c_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] c_TWO = c_ONE + c_ONE;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W:0]   r_len;
   logic              r_desc;
   logic              r_strict;
   // r_cnt is the number of cycles spent in SCAN; it is one bit wider than
   // the address so a full 2^ADDR_W array can be walked without wrapping.
   logic [ADDR_W:0]   r_cnt;
   logic [DATA_W-1:0] r_prev;
   logic              r_found;
   logic              r_sorted;
   logic [ADDR_W-1:0] r_inv_index;
   logic              r_busy;
   logic              r_done;

   logic              w_start;
   logic              w_short;
   logic              w_cmp_valid;
   logic              w_last_cmp;
   logic              w_gt;
   logic              w_lt;
   logic              w_eq;
   logic              w_inv;
   logic              w_hit;
   logic              w_stop_early;
   logic [ADDR_W-1:0] w_idx;

   assign w_start     = go && ((r_state == c_IDLE) || (r_state == c_DONE));
   assign w_short     = (length <= c_ONE);
   // rd_data in cycle c holds a[c-1]; a pair is available once two reads landed
   assign w_cmp_valid = (r_state == c_SCAN) && (r_cnt >= c_TWO) && (r_cnt <= r_len);
   assign w_last_cmp  = (r_state == c_SCAN) && (r_cnt == r_len);
   // element index of rd_data in this cycle (mod 2^ADDR_W keeps k=2^ADDR_W-1 right)
   assign w_idx       = r_cnt[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};

   generate
      if (SIGNED != 0) begin : g_signed
         assign w_gt = $signed(r_prev) > $signed(rd_data);
         assign w_lt = $signed(r_prev) < $signed(rd_data);
      end else begin : g_unsigned
         assign w_gt = r_prev > rd_data;
         assign w_lt = r_prev < rd_data;
      end
   endgenerate

   assign w_eq  = (r_prev == rd_data);
   assign w_inv = (r_desc ? w_lt : w_gt) || (r_strict && w_eq);
   assign w_hit = w_cmp_valid && w_inv;

`ifdef SORTCHK_COUNT_EN
   assign w_stop_early = 1'b0;
`else
   assign w_stop_early = w_hit;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= c_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE, c_DONE: if (go) w_state_nxt = w_short ? c_DONE : c_SCAN;
         c_SCAN:         if (w_last_cmp || w_stop_early) w_state_nxt = c_DONE;
         default:        w_state_nxt = c_IDLE;
      endcase
   end

   // Read strobe/address decoded from state and cycle counter
   always_comb begin
      rd_en   = (r_state == c_SCAN) && (r_cnt < r_len);
      rd_addr = rd_en ? r_cnt[ADDR_W-1:0] : '0;
   end

   // Datapath: latch job on go, advance scan, capture first inversion and result
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_len       <= '0;
         r_desc      <= 1'b0;
         r_strict    <= 1'b0;
         r_cnt       <= '0;
         r_prev      <= '0;
         r_found     <= 1'b0;
         r_sorted    <= 1'b0;
         r_inv_index <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == c_SCAN);
         r_done <= (w_state_nxt == c_DONE);
         if (w_start) begin
            r_len       <= length;
            r_desc      <= descending;
            r_strict    <= strict;
            r_cnt       <= '0;
            r_found     <= 1'b0;
            r_sorted    <= w_short;
            r_inv_index <= '0;
         end else if (r_state == c_SCAN) begin
            r_cnt  <= r_cnt + c_ONE;
            r_prev <= rd_data;
            if (w_hit && !r_found) begin
               r_inv_index <= w_idx;
               r_found     <= 1'b1;
            end
            if (w_state_nxt == c_DONE) r_sorted <= !(r_found || w_hit);
         end
      end
   end

`ifdef SORTCHK_COUNT_EN
   logic [ADDR_W:0] r_inv_count;

   // Saturating count of every inversion pair seen during the scan
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      r_inv_count <= '0;
      else if (w_start)                r_inv_count <= '0;
      else if (w_hit && (r_inv_count != {(ADDR_W+1){1'b1}}))
                                       r_inv_count <= r_inv_count + c_ONE;
   end

   assign inv_count = r_inv_count;
`endif

   assign busy      = r_busy;
   assign done      = r_done;
   assign sorted    = r_sorted;
   assign inv_index = r_inv_index;

endmodule
`default_nettype wire

// File: tb/tb_array_sort_check_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_sort_check_seq
// Purpose  : Directed bench for array_sort_check_seq with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_sort_check_seq;
   localparam int DW = 32;
   localparam int AW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          go = 1'b0;
   logic [AW:0]   length = '0;
   logic          descending = 1'b0;
   logic          strict = 1'b0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic          busy, done, sorted;
   logic [AW-1:0] inv_index;
`ifdef SORTCHK_COUNT_EN
   logic [AW:0]   inv_count;
`endif

   // small signed instance
   logic          go_s = 1'b0;
   logic [4:0]    length_s = '0;
   logic          desc_s = 1'b0;
   logic          strict_s = 1'b0;
   logic          rd_en_s;
   logic [3:0]    rd_addr_s;
   logic [7:0]    rd_data_s = '0;
   logic          busy_s, done_s, sorted_s;
   logic [3:0]    inv_index_s;
`ifdef SORTCHK_COUNT_EN
   logic [4:0]    inv_count_s;
`endif

   always #5 clock = ~clock;

   array_sort_check_seq #(.DATA_W(DW), .ADDR_W(AW), .SIGNED(0)) u_dut (
      .clock(clock), .reset(reset), .go(go), .length(length),
      .descending(descending), .strict(strict), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy), .done(done), .sorted(sorted),
      .inv_index(inv_index)
`ifdef SORTCHK_COUNT_EN
      , .inv_count(inv_count)
`endif
   );

   array_sort_check_seq #(.DATA_W(8), .ADDR_W(4), .SIGNED(1)) u_dut_s (
      .clock(clock), .reset(reset), .go(go_s), .length(length_s),
      .descending(desc_s), .strict(strict_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
      .rd_data(rd_data_s), .busy(busy_s), .done(done_s), .sorted(sorted_s),
      .inv_index(inv_index_s)
`ifdef SORTCHK_COUNT_EN
      , .inv_count(inv_count_s)
`endif
   );

   typedef struct {
      int    s;
      int    idx;
      int    lat;
      int    cnt;
      string nm;
   } exp_t;

   exp_t        sb[$];
   logic [DW-1:0] mem [0:255];
   logic [7:0]  mem_s [0:15];
   int          rd_hist [0:255];
   int          cyc = 0;
   int          reads = 0;
   int          cur_len = 0;
   int          go_cyc = 0;
   bit          overrun = 1'b0;
   bit          armed = 1'b0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // synchronous-read memory models plus read bookkeeping
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (rd_en) begin
         rd_data          <= mem[rd_addr];
         reads            <= reads + 1;
         rd_hist[rd_addr] <= rd_hist[rd_addr] + 1;
         if (int'(rd_addr) >= cur_len) overrun <= 1'b1;
      end
      if (rd_en_s) rd_data_s <= mem_s[rd_addr_s];
   end

   // monitor: first done after an accepted go is compared with the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (armed && done) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               e = sb.pop_front();
               chk({e.nm, "_sorted"}, int'(sorted), e.s);
               chk({e.nm, "_idx"}, int'(inv_index), e.idx);
               chk({e.nm, "_lat"}, cyc - go_cyc, e.lat);
               chk({e.nm, "_busy"}, int'(busy), 0);
`ifdef SORTCHK_COUNT_EN
               chk({e.nm, "_cnt"}, int'(inv_count), e.cnt);
`endif
            end
            armed = 1'b0;
         end
      end
   end

   // lat_early is the latency with early exit; glitch_at>0 pulses a go mid-scan
   task automatic run(input string nm, input int len, input bit desc, input bit str,
                      input int es, input int eidx, input int lat_early, input int ecnt,
                      input int glitch_at);
      exp_t e;
      int   elat;
`ifdef SORTCHK_COUNT_EN
      elat = (len <= 1) ? 0 : len + 1;
`else
      elat = lat_early;
`endif
      e.s = es; e.idx = eidx; e.lat = elat; e.cnt = ecnt; e.nm = nm;
      sb.push_back(e);
      @(negedge clock);
      length     = (AW+1)'(len);
      descending = desc;
      strict     = str;
      cur_len    = len;
      reads      = 0;
      overrun    = 1'b0;
      for (int i = 0; i < 256; i++) rd_hist[i] = 0;
      go = 1'b1;
      @(posedge clock);
      #1;
      go     = 1'b0;
      go_cyc = cyc;
      armed  = 1'b1;
      if (glitch_at > 0) begin
         repeat (glitch_at) @(negedge clock);
         length = '0; descending = ~desc; strict = ~str; go = 1'b1;
         @(negedge clock);
         go = 1'b0;
      end
      for (int i = 0; i < 2000 && armed; i++) @(negedge clock);
      if (armed) begin
         chk({nm, "_timeout"}, 1, 0);
         armed = 1'b0;
         sb.delete();
      end
      @(negedge clock);
      chk({nm, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      bit once;
      // reset state
      #2;
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sorted", int'(sorted), 0);
      chk("rst_idx", int'(inv_index), 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      // ascending, sorted, every address read once
      mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4; mem[4] = 5;
      run("asc5", 5, 0, 0, 1, 0, 6, 0, 0);
      chk("asc5_reads", reads, 5);
      once = 1'b1;
      for (int i = 0; i < 5; i++) if (rd_hist[i] != 1) once = 1'b0;
      chk("asc5_once", int'(once), 1);

      // single inversion in the middle
      mem[0] = 1; mem[1] = 3; mem[2] = 2; mem[3] = 4;
      run("inv4", 4, 0, 0, 0, 2, 4, 1, 0);

      // descending with equal neighbours, non-strict then strict
      mem[0] = 5; mem[1] = 5; mem[2] = 4;
      run("desc_ns", 3, 1, 0, 1, 0, 4, 0, 0);
      run("desc_st", 3, 1, 1, 0, 1, 3, 1, 0);

      // trivial lengths: no reads, done right after the go edge
      run("len0", 0, 0, 0, 1, 0, 0, 0, 0);
      chk("len0_reads", reads, 0);
      run("len1", 1, 0, 0, 1, 0, 0, 0, 0);
      chk("len1_reads", reads, 0);

      // unsigned view of 0xFF,0x01 is an inversion
      mem[0] = 32'hFF; mem[1] = 32'h01;
      run("uns2", 2, 0, 0, 0, 1, 3, 1, 0);

      // descending with the inversion on the last pair
      mem[0] = 9; mem[1] = 8; mem[2] = 7; mem[3] = 6; mem[4] = 5; mem[5] = 7;
      run("desc_last", 6, 1, 0, 0, 5, 7, 1, 0);

      // full-size array, with a go pulse mid-scan that must be ignored
      for (int i = 0; i < 256; i++) mem[i] = i;
      run("full256", 256, 0, 0, 1, 0, 257, 0, 10);
      chk("full256_reads", reads, 256);

      // signed instance: 0xFF (-1) then 0x01 is ascending
      mem_s[0] = 8'hFF; mem_s[1] = 8'h01;
      @(negedge clock);
      length_s = 5'd2; go_s = 1'b1;
      @(negedge clock);
      go_s = 1'b0;
      for (int i = 0; i < 100 && !done_s; i++) @(negedge clock);
      chk("sgn_done", int'(done_s), 1);
      chk("sgn_sorted", int'(sorted_s), 1);
      chk("sgn_idx", int'(inv_index_s), 0);
`ifdef SORTCHK_COUNT_EN
      chk("sgn_cnt", int'(inv_count_s), 0);
`endif

      // reset during a scan, then a fresh job
      for (int i = 0; i < 8; i++) mem[i] = i + 1;
      mem[7] = 0;
      @(negedge clock);
      length = 9'd8; descending = 1'b0; strict = 1'b0; cur_len = 8; go = 1'b1;
      @(posedge clock);
      #1;
      go = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_rd_en", int'(rd_en), 0);
      chk("abort_rd_addr", int'(rd_addr), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_sorted", int'(sorted), 0);
      chk("abort_idx", int'(inv_index), 0);
`ifdef SORTCHK_COUNT_EN
      chk("abort_cnt", int'(inv_count), 0);
`endif
      @(negedge clock);
      reset = 1'b1;
      mem[0] = 3; mem[1] = 1; mem[2] = 2;
      run("post_rst", 3, 0, 0, 0, 1, 3, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
